// File: rtl/empaquetador_pixeles_if.sv
// rtl/empaquetador_pixeles_if.sv - pixel stream, frame-memory write port and frame control
interface empaquetador_pixeles_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              pix_last;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, pix_valid, pix_data, pix_last, mem_ready,
        input  pix_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done
    );

    modport slave (
        input  start, pix_valid, pix_data, pix_last, mem_ready,
        output pix_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done
    );
endinterface

// File: rtl/empaquetador_pixeles.sv
// rtl/empaquetador_pixeles.sv - packs 8-bit pixels into 32-bit words and writes them to frame memory
module empaquetador_pixeles #(
    parameter int ADDR_W      = 17,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                 clk,
    input  logic                 reset,
    empaquetador_pixeles_if.slave bus
);
    localparam int                CNT_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t           state;
    logic [1:0]       lane_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic             last_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lane_cnt      <= '0;
            word_cnt      <= '0;
            last_flag     <= 1'b0;
            bus.pix_ready <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= FILL;
                        bus.mem_addr  <= BASE;
                        word_cnt      <= '0;
                        lane_cnt      <= '0;
                        bus.busy      <= 1'b1;
                        bus.pix_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.pix_valid && bus.pix_ready) begin
                        // Lane 0 is the first pixel: the VGA read path unpacks LSB first.
                        bus.mem_wdata[{lane_cnt, 3'b000} +: 8] <= bus.pix_data;
                        bus.mem_be[lane_cnt]                   <= 1'b1;
                        lane_cnt                               <= lane_cnt + 2'd1;
                        if (lane_cnt == 2'd3 || bus.pix_last) begin
                            state         <= WRITE;
                            bus.mem_we    <= 1'b1;
                            bus.pix_ready <= 1'b0;
                            last_flag     <= bus.pix_last;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '0;
                        lane_cnt      <= '0;
                        bus.mem_addr  <= bus.mem_addr + 1'b1;
                        word_cnt      <= word_cnt + 1'b1;
                        // The frame ends on pix_last or once the last word slot is used.
                        if (last_flag || word_cnt == LAST_WORD) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state         <= FILL;
                            bus.pix_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    last_flag <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_empaquetador_pixeles.sv
// tb/tb_empaquetador_pixeles.sv - self-checking bench for empaquetador_pixeles
module tb_empaquetador_pixeles;
    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    empaquetador_pixeles_if #(.ADDR_W(17)) a ();
    empaquetador_pixeles_if #(.ADDR_W(17)) b ();

    empaquetador_pixeles #(.ADDR_W(17), .BASE_ADDR(0), .FRAME_WORDS(19200)) dut (
        .clk(clk), .reset(reset), .bus(a)
    );
    empaquetador_pixeles #(.ADDR_W(17), .BASE_ADDR(0), .FRAME_WORDS(2)) dut_lim (
        .clk(clk), .reset(reset), .bus(b)
    );

    int n_cmp = 0;
    int n_fail = 0;
    wr_t wr_a[$];
    wr_t wr_b[$];
    wr_t exp_q[$];
    bit [8:0] px_q[$];
    int done_a = 0;
    int done_b = 0;

    always @(negedge clk) begin
        if (a.mem_we && a.mem_ready) wr_a.push_back({a.mem_addr, a.mem_be, a.mem_wdata});
        if (b.mem_we && b.mem_ready) wr_b.push_back({b.mem_addr, b.mem_be, b.mem_wdata});
        if (a.done) done_a++;
        if (b.done) done_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: group accepted pixels into words of four (or up to pix_last), zero-fill unused lanes.
    task automatic build_expected(input int fw);
        wr_t w;
        int lane;
        exp_q.delete();
        w = '0;
        lane = 0;
        foreach (px_q[i]) begin
            if (exp_q.size() < fw) begin
                w.data[8*lane +: 8] = px_q[i][7:0];
                w.be[lane] = 1'b1;
                lane++;
                if (lane == 4 || px_q[i][8]) begin
                    w.addr = 17'(exp_q.size());
                    exp_q.push_back(w);
                    w = '0;
                    lane = 0;
                end
            end
        end
    endtask

    task automatic push_pix(input bit on_b, input logic [7:0] d, input logic l, input int limit, output bit ok);
        ok = 1'b0;
        if (on_b) begin b.pix_valid = 1'b1; b.pix_data = d; b.pix_last = l; end
        else begin a.pix_valid = 1'b1; a.pix_data = d; a.pix_last = l; end
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if ((on_b ? b.pix_ready : a.pix_ready) === 1'b1) begin ok = 1'b1; break; end
        end
        step();
        if (on_b) begin b.pix_valid = 1'b0; b.pix_last = 1'b0; end
        else begin a.pix_valid = 1'b0; a.pix_last = 1'b0; end
    endtask

    task automatic pulse_start_a();
        a.start = 1'b1;
        step();
        a.start = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (a.done === 1'b1) begin cyc = n; break; end
        end
    endtask

    task automatic finish_frame_a(input string name);
        int cyc;
        wait_done_a(cyc);
        n_cmp++;
        if (cyc < 0) begin n_fail++; $display("FAIL %s_done: got no done pulse, expected one", name); end
        @(negedge clk);
        n_cmp++;
        if ({a.done, a.busy} !== 2'b00) begin
            n_fail++; $display("FAIL %s_after_done: got done,busy=%b expected 00", name, {a.done, a.busy});
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a.pix_ready, a.mem_we, a.busy, a.done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {a.pix_ready, a.mem_we, a.busy, a.done});
        end
        n_cmp++;
        if ({a.mem_addr, a.mem_wdata, a.mem_be} !== '0) begin
            n_fail++; $display("FAIL reset_bus: got addr=%h data=%h be=%b expected 0", a.mem_addr, a.mem_wdata, a.mem_be);
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if (a.pix_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b expected 0", a.pix_ready); end
        step();
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] pix [4];
        pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
        a.mem_ready = 1'b1;
        wr_a.delete();
        pulse_start_a();
        for (int i = 0; i < 4; i++) push_pix(1'b0, pix[i], 1'b0, 10, ok);
        @(negedge clk);
        n_cmp++;
        if ({a.mem_we, a.pix_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_we: got we,ready=%b expected 10", {a.mem_we, a.pix_ready}); end
        n_cmp++;
        if ({a.mem_addr, a.mem_be, a.mem_wdata} !== {17'd0, 4'b1111, 32'h44332211}) begin
            n_fail++; $display("FAIL basic_word: got addr=%h be=%b data=%h expected 0/1111/44332211", a.mem_addr, a.mem_be, a.mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({a.mem_we, a.pix_ready, a.mem_addr} !== {2'b01, 17'd1}) begin
            n_fail++; $display("FAIL basic_after: got we=%b ready=%b addr=%h expected 0/1/1", a.mem_we, a.pix_ready, a.mem_addr);
        end
        step();
        push_pix(1'b0, 8'h55, 1'b1, 10, ok);
        finish_frame_a("basic");
    endtask

    task automatic test_backpressure();
        bit ok;
        a.mem_ready = 1'b0;
        pulse_start_a();
        for (int i = 0; i < 4; i++) push_pix(1'b0, 8'(8'hA0 + i), 1'b0, 10, ok);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a.mem_we, a.pix_ready, a.mem_addr, a.mem_wdata} !== {2'b10, 17'd0, 32'hA3A2A1A0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got we=%b ready=%b addr=%h data=%h expected 1/0/0/a3a2a1a0", c, a.mem_we, a.pix_ready, a.mem_addr, a.mem_wdata);
            end
        end
        a.mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a.mem_we, a.mem_addr} !== {1'b0, 17'd1}) begin
            n_fail++; $display("FAIL bp_release: got we=%b addr=%h expected 0/1", a.mem_we, a.mem_addr);
        end
        step();
        push_pix(1'b0, 8'h01, 1'b1, 10, ok);
        finish_frame_a("bp");
    endtask

    task automatic test_partial();
        bit ok;
        a.mem_ready = 1'b1;
        pulse_start_a();
        push_pix(1'b0, 8'hAA, 1'b0, 10, ok);
        push_pix(1'b0, 8'hBB, 1'b1, 10, ok);
        @(negedge clk);
        n_cmp++;
        if ({a.mem_we, a.mem_be, a.mem_wdata} !== {1'b1, 4'b0011, 32'h0000BBAA}) begin
            n_fail++; $display("FAIL partial_word: got we=%b be=%b data=%h expected 1/0011/0000bbaa", a.mem_we, a.mem_be, a.mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (a.done !== 1'b1) begin n_fail++; $display("FAIL partial_done: got %b expected 1", a.done); end
        @(negedge clk);
        n_cmp++;
        if ({a.done, a.busy} !== 2'b00) begin n_fail++; $display("FAIL partial_idle: got done,busy=%b expected 00", {a.done, a.busy}); end
        step();
    endtask

    task automatic test_word_limit();
        bit ok;
        int acc;
        int rej_late;
        b.mem_ready = 1'b1;
        wr_b.delete();
        px_q.delete();
        done_b = 0;
        acc = 0;
        rej_late = 0;
        b.start = 1'b1;
        step();
        b.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            px_q.push_back({1'b0, d});
            push_pix(1'b1, d, 1'b0, 10, ok);
            if (ok) acc++;
            if (i >= 8 && !ok) rej_late++;
        end
        build_expected(2);
        n_cmp++;
        if (acc !== 8 || rej_late !== 4) begin n_fail++; $display("FAIL limit_accept: got accepted=%0d late_rejected=%0d expected 8/4", acc, rej_late); end
        n_cmp++;
        if (wr_b.size() !== 2) begin n_fail++; $display("FAIL limit_writes: got %0d expected 2", wr_b.size()); end
        for (int i = 0; i < 2 && i < wr_b.size(); i++) begin
            n_cmp++;
            if (wr_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL limit_word%0d: got %h expected %h", i, wr_b[i], exp_q[i]); end
        end
        n_cmp++;
        if (done_b !== 1 || b.busy !== 1'b0) begin n_fail++; $display("FAIL limit_done: got pulses=%0d busy=%b expected 1/0", done_b, b.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        a.mem_ready = 1'b1;
        pulse_start_a();
        for (int i = 0; i < 3; i++) push_pix(1'b0, 8'(8'h70 + i), 1'b0, 10, ok);
        wr_a.delete();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({a.pix_ready, a.mem_we, a.busy, a.done, a.mem_be, a.mem_wdata, a.mem_addr} !== '0) begin
            n_fail++; $display("FAIL async_reset: got ready=%b we=%b busy=%b be=%b data=%h expected all 0", a.pix_ready, a.mem_we, a.busy, a.mem_be, a.mem_wdata);
        end
        step();
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (wr_a.size() !== 0) begin n_fail++; $display("FAIL reset_nowrite: got %0d writes expected 0", wr_a.size()); end
        pulse_start_a();
        for (int i = 0; i < 4; i++) push_pix(1'b0, 8'(i + 1), 1'b0, 10, ok);
        @(negedge clk);
        n_cmp++;
        if ({a.mem_addr, a.mem_be, a.mem_wdata} !== {17'd0, 4'b1111, 32'h04030201}) begin
            n_fail++; $display("FAIL reset_restart: got addr=%h be=%b data=%h expected 0/1111/04030201", a.mem_addr, a.mem_be, a.mem_wdata);
        end
        step();
        push_pix(1'b0, 8'h05, 1'b1, 10, ok);
        finish_frame_a("restart");
    endtask

    task automatic test_start_in_fill();
        bit ok;
        a.mem_ready = 1'b1;
        wr_a.delete();
        px_q.delete();
        pulse_start_a();
        for (int i = 0; i < 9; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            px_q.push_back({(i == 8) ? 1'b1 : 1'b0, d});
            push_pix(1'b0, d, (i == 8) ? 1'b1 : 1'b0, 10, ok);
            if (i == 3) begin
                step();
                pulse_start_a();
            end
        end
        finish_frame_a("restart_ignored");
        build_expected(19200);
        n_cmp++;
        if (wr_a.size() !== 3) begin n_fail++; $display("FAIL start_fill_count: got %0d expected 3", wr_a.size()); end
        for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL start_fill_word%0d: got %h expected %h", i, wr_a[i], exp_q[i]); end
        end
    endtask

    task automatic test_random(input int iter);
        bit ok;
        bit stop;
        int npix;
        int acc;
        a.mem_ready = 1'b1;
        wr_a.delete();
        px_q.delete();
        npix = $urandom_range(5, 40);
        acc = 0;
        stop = 1'b0;
        for (int i = 0; i < npix; i++) px_q.push_back({(i == npix - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        pulse_start_a();
        fork
            begin
                while (!stop) begin
                    step();
                    a.mem_ready = ($urandom_range(0, 2) != 0);
                end
                a.mem_ready = 1'b1;
            end
            begin
                foreach (px_q[i]) begin
                    repeat ($urandom_range(0, 2)) step();
                    push_pix(1'b0, px_q[i][7:0], px_q[i][8], 60, ok);
                    if (ok) acc++;
                end
                stop = 1'b1;
            end
        join
        finish_frame_a("random");
        build_expected(19200);
        n_cmp++;
        if (acc !== npix || wr_a.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL random%0d_count: got accepted=%0d writes=%0d expected %0d/%0d", iter, acc, wr_a.size(), npix, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL random%0d_word%0d: got %h expected %h", iter, i, wr_a[i], exp_q[i]); end
        end
    endtask

    initial begin
        a.start = 1'b0; a.pix_valid = 1'b0; a.pix_data = '0; a.pix_last = 1'b0; a.mem_ready = 1'b0;
        b.start = 1'b0; b.pix_valid = 1'b0; b.pix_data = '0; b.pix_last = 1'b0; b.mem_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_partial();
        test_word_limit();
        test_reset_mid();
        test_start_in_fill();
        for (int k = 0; k < 4; k++) test_random(k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
